rvj1_mem_arb: RTL and testbench
===============================

# rvj1_mem_arb

Two-to-one memory port arbiter for the rvj1 core. It shares the single memory bus between the instruction fetch path (IFU) and the load/store unit (LSU). Exactly one transaction is outstanding at a time. Responses are routed back to the requester that owns the transaction. LSU normally has priority; a starvation counter guarantees IFU forward progress. The block sits between the IFU/LSU request ports and the external instruction/data memory.

## Interface

Parameters:
- XLEN, 32, address and data width.
- STARVE_LIMIT, 4, number of consecutive LSU grants (with IFU waiting) after which IFU gets priority. Range 1..15.

Ports:
- clk_i  in  1  core clock, all state updates on rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- ifu_req_i  in  1  IFU read request; held with ifu_addr_i stable until ifu_gnt_o.
- ifu_addr_i  in  XLEN  IFU word address.
- ifu_gnt_o  out  1  IFU request accepted by memory this cycle.
- ifu_rvalid_o  out  1  IFU response valid.
- ifu_rdata_o  out  XLEN  IFU response data (mirrors mem_rdata_i).
- lsu_req_i  in  1  LSU request; held with all LSU fields stable until lsu_gnt_o.
- lsu_we_i  in  1  1 = store.
- lsu_be_i  in  XLEN/8  byte enables.
- lsu_addr_i  in  XLEN  LSU address.
- lsu_wdata_i  in  XLEN  store data.
- lsu_gnt_o  out  1  LSU request accepted.
- lsu_rvalid_o  out  1  LSU response valid (loads and stores).
- lsu_rdata_o  out  XLEN  LSU response data (mirrors mem_rdata_i).
- lsu_err_o  out  1  LSU response error, qualified by lsu_rvalid_o.
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/1/XLEN/8/XLEN/XLEN  memory request bus.
- mem_gnt_i  in  1  memory accepts the request.
- mem_rvalid_i  in  1  memory response valid, earliest one cycle after gnt.
- mem_rdata_i  in  XLEN  response data.
- mem_err_i  in  1  response error.
- busy_o  out  1  a transaction is pending or outstanding (state != IDLE).
- proto_err_o  out  1  sticky; set on mem_rvalid_i in IDLE or REQ_*; cleared only by reset.

## Operation

- States: IDLE, REQ_IFU, REQ_LSU (request presented, not yet granted; selection locked), WAIT_IFU, WAIT_LSU (granted, awaiting rvalid).
- Arbitration window: state IDLE, or WAIT_* in the cycle mem_rvalid_i = 1. This gives back-to-back issue with no bubble.
- Winner in the window:
  - LSU if lsu_req_i, unless ifu_req_i and starve_cnt == STARVE_LIMIT, in which case IFU wins.
  - Otherwise IFU if ifu_req_i.
- The winner's fields drive mem_*; mem_req_o = 1.
  - IFU transactions drive mem_we_o = 0 and mem_be_o = all ones.
  - Otherwise mem_we_o/be/addr/wdata = 0.
- Transition out of the window: if mem_gnt_i, go to WAIT_winner; else go to REQ_winner; with no request, go to IDLE.
- REQ_x: mem_* is driven from requester x only, with mem_req_o = x_req_i.
  - mem_gnt_i → WAIT_x.
  - x_req_i dropped → IDLE. This is a requester violation; there is no error.
  - The other requester is never granted while in REQ_x.
- gnt routing: x_gnt_o = mem_gnt_i && mem_req_o && (selected == x). The non-selected gnt is 0.
- WAIT_x, response routing:
  - mem_rvalid_i drives x_rvalid_o.
  - lsu_err_o = mem_err_i when the owner is LSU; mem_err_i is ignored for IFU.
  - The other rvalid is 0.
- Both rdata outputs always mirror mem_rdata_i.
- starve_cnt is 4 bits:
  - It increments, saturating at STARVE_LIMIT, on an LSU grant while ifu_req_i = 1.
  - It clears on an IFU grant, and on an LSU grant while ifu_req_i = 0.
- mem_rvalid_i in IDLE/REQ_*: dropped (no rvalid routed), proto_err_o set, state unchanged.

## Timing

- Reset (asynchronous assert, rstn_i = 0):
  - state = IDLE, starve_cnt = 0, proto_err_o = 0.
  - All outputs are combinationally 0 during reset.
  - A transaction in flight at reset is abandoned; its late rvalid after reset sets proto_err_o.
- Request path: zero added latency.
  - mem_req_o follows x_req_i combinationally in the window.
  - gnt returns combinationally in the same cycle.
- Response path: zero added latency. mem_rvalid_i → x_rvalid_o combinationally.
- Simultaneous rvalid and new grant in one cycle: the response goes to the old owner, and the state moves to WAIT of the new winner.
- Maximum throughput: one transaction per cycle when memory returns rvalid one cycle after gnt.
- No combinational path from rvalid to any requester input; timing paths are mem_gnt_i→x_gnt_o and mem_rvalid_i→mem_req_o.

## Test plan

- **Single IFU fetch.** Stimulus: ifu_req_i = 1, addr 0x100; mem_gnt_i = 1 immediately; rvalid 2 cycles later with rdata 0x00000013. Required: ifu_gnt_o = 1 in cycle 0; ifu_rvalid_o = 1 exactly once; lsu_rvalid_o = 0; busy_o = 1 until the response.
- **Collision.** Stimulus: ifu_req_i and lsu_req_i (load, 0x2000) asserted in the same cycle. Required: LSU granted first; IFU granted in the cycle of the LSU rvalid; starve_cnt = 1 then 0.
- **Starvation.** Stimulus: lsu_req_i held with back-to-back loads, ifu_req_i held, STARVE_LIMIT = 4. Required: 4 LSU grants, then the 5th grant goes to IFU, then LSU again.
- **Locked selection.** Stimulus: IFU presents with mem_gnt_i = 0 for 3 cycles; lsu_req_i rises in cycle 1. Required: mem_addr_o stays the IFU address; lsu_gnt_o = 0; IFU is granted when mem_gnt_i = 1.
- **Store error.** Stimulus: LSU store with be = 0b0011, wdata 0xDEADBEEF; response with mem_err_i = 1. Required: mem_we_o = 1 and mem_be_o = 0b0011 during the request; lsu_rvalid_o = 1 and lsu_err_o = 1 on the response.
- **Reset mid-transaction and stray rvalid.** Stimulus: rstn_i pulsed low while in WAIT_LSU; the late rvalid then arrives. Required: outputs go to 0 immediately on reset; the late rvalid is dropped and proto_err_o = 1.

Source files
------------

// File: rtl/rvj1_mem_arb.sv
// Two-to-one memory port arbiter: IFU and LSU share one memory bus, one transaction outstanding.
// LSU has priority; a starvation counter hands the bus to a waiting IFU after STARVE_LIMIT LSU grants.
module rvj1_mem_arb #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              ifu_req_i,
   input  logic [XLEN-1:0]   ifu_addr_i,
   output logic              ifu_gnt_o,
   output logic              ifu_rvalid_o,
   output logic [XLEN-1:0]   ifu_rdata_o,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [XLEN/8-1:0] lsu_be_i,
   input  logic [XLEN-1:0]   lsu_addr_i,
   input  logic [XLEN-1:0]   lsu_wdata_i,
   output logic              lsu_gnt_o,
   output logic              lsu_rvalid_o,
   output logic [XLEN-1:0]   lsu_rdata_o,
   output logic              lsu_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              mem_err_i,
   output logic              busy_o,
   output logic              proto_err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_IFU,
      S_REQ_LSU,
      S_WAIT_IFU,
      S_WAIT_LSU
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t            r_state;
   state_t            w_state_next;
   logic [3:0]        r_starve_cnt;
   logic [3:0]        w_starve_next;
   logic              r_proto_err;
   logic              w_proto_err_next;

   logic              w_in_wait;
   logic              w_in_req;
   logic              w_window;
   logic              w_lsu_wins;
   logic              w_ifu_wins;
   logic              w_sel_ifu;
   logic              w_sel_lsu;
   logic              w_req;
   logic              w_ifu_gnt;
   logic              w_lsu_gnt;
   logic              w_we;
   logic [XLEN/8-1:0] w_be;
   logic [XLEN-1:0]   w_addr;
   logic [XLEN-1:0]   w_wdata;

   assign w_in_wait  = (r_state == S_WAIT_IFU) || (r_state == S_WAIT_LSU);
   assign w_in_req   = (r_state == S_REQ_IFU) || (r_state == S_REQ_LSU);
   assign w_window   = (r_state == S_IDLE) || (w_in_wait && mem_rvalid_i);
   assign w_lsu_wins = lsu_req_i && !(ifu_req_i && (r_starve_cnt == LIMIT));
   assign w_ifu_wins = ifu_req_i && !w_lsu_wins;

   // Selection is re-evaluated only in the window; REQ_* keeps it locked until granted or dropped.
   always_comb begin
      w_sel_ifu = 1'b0;
      w_sel_lsu = 1'b0;
      if (w_window) begin
         w_sel_ifu = w_ifu_wins;
         w_sel_lsu = w_lsu_wins;
      end else if (r_state == S_REQ_IFU) begin
         w_sel_ifu = 1'b1;
      end else if (r_state == S_REQ_LSU) begin
         w_sel_lsu = 1'b1;
      end
   end

   assign w_req     = (w_sel_ifu && ifu_req_i) || (w_sel_lsu && lsu_req_i);
   assign w_ifu_gnt = mem_gnt_i && w_req && w_sel_ifu;
   assign w_lsu_gnt = mem_gnt_i && w_req && w_sel_lsu;

   always_comb begin
      w_we    = 1'b0;
      w_be    = '0;
      w_addr  = '0;
      w_wdata = '0;
      if (w_sel_ifu) begin
         w_be   = '1;
         w_addr = ifu_addr_i;
      end else if (w_sel_lsu) begin
         w_we    = lsu_we_i;
         w_be    = lsu_be_i;
         w_addr  = lsu_addr_i;
         w_wdata = lsu_wdata_i;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_window) begin
         if (w_sel_lsu)
            w_state_next = mem_gnt_i ? S_WAIT_LSU : S_REQ_LSU;
         else if (w_sel_ifu)
            w_state_next = mem_gnt_i ? S_WAIT_IFU : S_REQ_IFU;
         else
            w_state_next = S_IDLE;
      end else if (r_state == S_REQ_IFU) begin
         if (!ifu_req_i)
            w_state_next = S_IDLE;
         else if (mem_gnt_i)
            w_state_next = S_WAIT_IFU;
      end else if (r_state == S_REQ_LSU) begin
         if (!lsu_req_i)
            w_state_next = S_IDLE;
         else if (mem_gnt_i)
            w_state_next = S_WAIT_LSU;
      end
   end

   always_comb begin
      w_starve_next = r_starve_cnt;
      if (w_lsu_gnt) begin
         if (!ifu_req_i)
            w_starve_next = 4'd0;
         else if (r_starve_cnt >= LIMIT)
            w_starve_next = LIMIT;
         else
            w_starve_next = r_starve_cnt + 4'd1;
      end else if (w_ifu_gnt) begin
         w_starve_next = 4'd0;
      end
   end

   // A response with nothing outstanding is a memory-side protocol violation.
   assign w_proto_err_next = r_proto_err || (mem_rvalid_i && ((r_state == S_IDLE) || w_in_req));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= S_IDLE;
         r_starve_cnt <= 4'd0;
         r_proto_err  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_starve_cnt <= w_starve_next;
         r_proto_err  <= w_proto_err_next;
      end
   end

   // Every output is forced low while reset is asserted, independent of the inputs.
   assign mem_req_o    = rstn_i && w_req;
   assign mem_we_o     = rstn_i && w_we;
   assign mem_be_o     = {(XLEN/8){rstn_i}} & w_be;
   assign mem_addr_o   = {XLEN{rstn_i}} & w_addr;
   assign mem_wdata_o  = {XLEN{rstn_i}} & w_wdata;
   assign ifu_gnt_o    = rstn_i && w_ifu_gnt;
   assign lsu_gnt_o    = rstn_i && w_lsu_gnt;
   assign ifu_rvalid_o = rstn_i && (r_state == S_WAIT_IFU) && mem_rvalid_i;
   assign lsu_rvalid_o = rstn_i && (r_state == S_WAIT_LSU) && mem_rvalid_i;
   assign lsu_err_o    = rstn_i && (r_state == S_WAIT_LSU) && mem_rvalid_i && mem_err_i;
   assign ifu_rdata_o  = {XLEN{rstn_i}} & mem_rdata_i;
   assign lsu_rdata_o  = {XLEN{rstn_i}} & mem_rdata_i;
   assign busy_o       = rstn_i && (r_state != S_IDLE);
   assign proto_err_o  = rstn_i && r_proto_err;

endmodule

// File: tb/tb_rvj1_mem_arb.sv
// Bench for rvj1_mem_arb: directed test-plan scenarios followed by randomized traffic,
// all cycles compared against a transaction-level owner/lock model of the arbiter.
module tb_rvj1_mem_arb;
   localparam int XLEN  = 32;
   localparam int LIMIT = 4;

   logic              clk = 1'b0;
   logic              rstn_i;
   logic              ifu_req_i;
   logic [XLEN-1:0]   ifu_addr_i;
   logic              ifu_gnt_o, ifu_rvalid_o;
   logic [XLEN-1:0]   ifu_rdata_o;
   logic              lsu_req_i, lsu_we_i;
   logic [XLEN/8-1:0] lsu_be_i;
   logic [XLEN-1:0]   lsu_addr_i, lsu_wdata_i;
   logic              lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
   logic [XLEN-1:0]   lsu_rdata_o;
   logic              mem_req_o, mem_we_o;
   logic [XLEN/8-1:0] mem_be_o;
   logic [XLEN-1:0]   mem_addr_o, mem_wdata_o;
   logic              mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [XLEN-1:0]   mem_rdata_i;
   logic              busy_o, proto_err_o;

   int n_checks = 0;
   int n_errors = 0;

   // Model: owner of the granted transaction and requester locked onto the bus (0 none, 1 IFU, 2 LSU).
   int m_owner = 0, m_lock = 0, m_starve = 0;
   bit m_perr = 1'b0;
   bit e_ifu_gnt, e_lsu_gnt;

   // Outputs sampled by the last step, for scenario-specific checks.
   logic [31:0] s_ifu_gnt, s_lsu_gnt, s_ifu_rvalid, s_lsu_rvalid, s_lsu_err;
   logic [31:0] s_mem_addr, s_mem_we, s_mem_be, s_busy, s_perr;

   always #5 clk = ~clk;

   rvj1_mem_arb #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
      .clk_i(clk), .rstn_i(rstn_i),
      .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
      .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
      .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .busy_o(busy_o), .proto_err_o(proto_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".mem_req"}, 32'(mem_req_o), 32'd0);
      chk({tag, ".mem_we"}, 32'(mem_we_o), 32'd0);
      chk({tag, ".mem_be"}, 32'(mem_be_o), 32'd0);
      chk({tag, ".mem_addr"}, mem_addr_o, 32'd0);
      chk({tag, ".mem_wdata"}, mem_wdata_o, 32'd0);
      chk({tag, ".gnts"}, 32'({ifu_gnt_o, lsu_gnt_o}), 32'd0);
      chk({tag, ".rvalids"}, 32'({ifu_rvalid_o, lsu_rvalid_o, lsu_err_o}), 32'd0);
      chk({tag, ".ifu_rdata"}, ifu_rdata_o, 32'd0);
      chk({tag, ".lsu_rdata"}, lsu_rdata_o, 32'd0);
      chk({tag, ".busy"}, 32'(busy_o), 32'd0);
      chk({tag, ".proto_err"}, 32'(proto_err_o), 32'd0);
   endtask

   task automatic model_reset();
      m_owner = 0; m_lock = 0; m_starve = 0; m_perr = 1'b0;
   endtask

   // One clock cycle: compare outputs at the falling edge, then advance the model at the rising edge.
   task automatic step(input string tag);
      int  sel, n_owner, n_lock, n_starve;
      bit  window, req, n_perr;
      logic [31:0] x_addr, x_wdata, x_be, x_we;
      @(negedge clk);
      s_ifu_gnt = 32'(ifu_gnt_o);       s_lsu_gnt = 32'(lsu_gnt_o);
      s_ifu_rvalid = 32'(ifu_rvalid_o); s_lsu_rvalid = 32'(lsu_rvalid_o);
      s_lsu_err = 32'(lsu_err_o);       s_mem_addr = mem_addr_o;
      s_mem_we = 32'(mem_we_o);         s_mem_be = 32'(mem_be_o);
      s_busy = 32'(busy_o);             s_perr = 32'(proto_err_o);
      e_ifu_gnt = 1'b0; e_lsu_gnt = 1'b0;
      if (!rstn_i) begin
         chk_zero({tag, ".rst"});
         @(posedge clk);
         model_reset();
         #1;
         return;
      end
      window = (m_owner == 0 && m_lock == 0) || (m_owner != 0 && mem_rvalid_i);
      sel = 0;
      if (m_lock != 0) sel = m_lock;
      else if (window) begin
         if (lsu_req_i && !(ifu_req_i && m_starve == LIMIT)) sel = 2;
         else if (ifu_req_i) sel = 1;
      end
      req = (sel == 1 && ifu_req_i) || (sel == 2 && lsu_req_i);
      e_ifu_gnt = mem_gnt_i && req && sel == 1;
      e_lsu_gnt = mem_gnt_i && req && sel == 2;
      chk({tag, ".mem_req"}, 32'(mem_req_o), 32'(req));
      chk({tag, ".ifu_gnt"}, 32'(ifu_gnt_o), 32'(e_ifu_gnt));
      chk({tag, ".lsu_gnt"}, 32'(lsu_gnt_o), 32'(e_lsu_gnt));
      chk({tag, ".ifu_rvalid"}, 32'(ifu_rvalid_o), 32'(mem_rvalid_i && m_owner == 1));
      chk({tag, ".lsu_rvalid"}, 32'(lsu_rvalid_o), 32'(mem_rvalid_i && m_owner == 2));
      if (mem_rvalid_i && m_owner == 2)
         chk({tag, ".lsu_err"}, 32'(lsu_err_o), 32'(mem_err_i));
      chk({tag, ".busy"}, 32'(busy_o), 32'(m_owner != 0 || m_lock != 0));
      chk({tag, ".proto_err"}, 32'(proto_err_o), 32'(m_perr));
      chk({tag, ".ifu_rdata"}, ifu_rdata_o, mem_rdata_i);
      chk({tag, ".lsu_rdata"}, lsu_rdata_o, mem_rdata_i);
      if (req) begin
         x_we    = (sel == 2) ? 32'(lsu_we_i) : 32'd0;
         x_be    = (sel == 2) ? 32'(lsu_be_i) : 32'hF;
         x_addr  = (sel == 2) ? lsu_addr_i : ifu_addr_i;
         x_wdata = (sel == 2) ? lsu_wdata_i : 32'd0;
         chk({tag, ".mem_we"}, 32'(mem_we_o), x_we);
         chk({tag, ".mem_be"}, 32'(mem_be_o), x_be);
         chk({tag, ".mem_addr"}, mem_addr_o, x_addr);
         chk({tag, ".mem_wdata"}, mem_wdata_o, x_wdata);
      end
      n_owner = m_owner; n_lock = m_lock; n_starve = m_starve;
      n_perr = m_perr || (mem_rvalid_i && m_owner == 0);
      if (e_ifu_gnt || e_lsu_gnt) begin
         n_owner = sel; n_lock = 0;
         if (e_ifu_gnt) n_starve = 0;
         else n_starve = ifu_req_i ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end else if (req) begin
         n_owner = 0; n_lock = sel;
      end else if (m_lock != 0) begin
         n_lock = 0;
      end else if (window) begin
         n_owner = 0;
      end
      @(posedge clk);
      m_owner = n_owner; m_lock = n_lock; m_starve = n_starve; m_perr = n_perr;
      #1;
   endtask

   task automatic idle_inputs();
      ifu_req_i = 0; ifu_addr_i = '0;
      lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
   endtask

   initial begin
      bit win_lsu [6];
      win_lsu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      // Reset with busy-looking inputs: every output must be held at zero.
      rstn_i = 0;
      idle_inputs();
      ifu_req_i = 1; ifu_addr_i = 32'h100; lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'hF;
      mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
      #2 chk_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      idle_inputs();
      rstn_i = 1;
      model_reset();
      step("idle");

      // Single IFU fetch.
      ifu_req_i = 1; ifu_addr_i = 32'h100; mem_gnt_i = 1;
      step("fetch.c0");
      chk("fetch.gnt", s_ifu_gnt, 32'd1);
      ifu_req_i = 0; mem_gnt_i = 0;
      step("fetch.c1");
      chk("fetch.busy", s_busy, 32'd1);
      mem_rvalid_i = 1; mem_rdata_i = 32'h00000013;
      step("fetch.c2");
      chk("fetch.ifu_rvalid", s_ifu_rvalid, 32'd1);
      chk("fetch.lsu_rvalid", s_lsu_rvalid, 32'd0);
      mem_rvalid_i = 0;
      step("fetch.c3");
      chk("fetch.rvalid_once", s_ifu_rvalid, 32'd0);
      chk("fetch.idle", s_busy, 32'd0);

      // Collision: LSU first, IFU in the LSU response cycle.
      ifu_req_i = 1; ifu_addr_i = 32'h104; lsu_req_i = 1; lsu_addr_i = 32'h2000; mem_gnt_i = 1;
      step("coll.c0");
      chk("coll.lsu_first", s_lsu_gnt, 32'd1);
      chk("coll.ifu_wait", s_ifu_gnt, 32'd0);
      lsu_req_i = 0; mem_gnt_i = 0;
      step("coll.c1");
      mem_rvalid_i = 1; mem_gnt_i = 1; mem_rdata_i = 32'hCAFE0001;
      step("coll.c2");
      chk("coll.lsu_rvalid", s_lsu_rvalid, 32'd1);
      chk("coll.ifu_gnt", s_ifu_gnt, 32'd1);
      ifu_req_i = 0; mem_gnt_i = 0;
      step("coll.c3");
      chk("coll.ifu_rvalid", s_ifu_rvalid, 32'd1);
      mem_rvalid_i = 0;
      step("coll.c4");

      // Starvation: four LSU grants, then IFU, then LSU again.
      ifu_req_i = 1; ifu_addr_i = 32'h200; lsu_req_i = 1; lsu_addr_i = 32'h2100; mem_gnt_i = 1;
      for (int k = 0; k < 6; k++) begin
         mem_rvalid_i = (k > 0);
         mem_rdata_i = 32'(k);
         step($sformatf("starve.c%0d", k));
         chk($sformatf("starve.lsu_gnt%0d", k), s_lsu_gnt, 32'(win_lsu[k]));
         chk($sformatf("starve.ifu_gnt%0d", k), s_ifu_gnt, 32'(!win_lsu[k]));
      end
      ifu_req_i = 0; lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      step("starve.drain");
      mem_rvalid_i = 0;
      step("starve.idle");

      // Locked selection: IFU keeps the bus while ungranted even when LSU arrives.
      ifu_req_i = 1; ifu_addr_i = 32'h200; mem_gnt_i = 0;
      step("lock.c0");
      lsu_req_i = 1; lsu_addr_i = 32'h3000;
      for (int k = 1; k < 3; k++) begin
         step($sformatf("lock.c%0d", k));
         chk($sformatf("lock.addr%0d", k), s_mem_addr, 32'h200);
         chk($sformatf("lock.lsu_gnt%0d", k), s_lsu_gnt, 32'd0);
      end
      mem_gnt_i = 1;
      step("lock.c3");
      chk("lock.ifu_gnt", s_ifu_gnt, 32'd1);
      chk("lock.lsu_gnt3", s_lsu_gnt, 32'd0);
      ifu_req_i = 0; mem_gnt_i = 0;
      step("lock.c4");
      mem_rvalid_i = 1; mem_gnt_i = 1;
      step("lock.c5");
      chk("lock.ifu_rvalid", s_ifu_rvalid, 32'd1);
      chk("lock.lsu_gnt5", s_lsu_gnt, 32'd1);
      lsu_req_i = 0; mem_gnt_i = 0;
      step("lock.c6");
      mem_rvalid_i = 0;
      step("lock.c7");

      // Store with error response.
      lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'b0011; lsu_addr_i = 32'h40;
      lsu_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1;
      step("store.c0");
      chk("store.we", s_mem_we, 32'd1);
      chk("store.be", s_mem_be, 32'h3);
      lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = '0; lsu_wdata_i = '0; mem_gnt_i = 0;
      mem_rvalid_i = 1; mem_err_i = 1;
      step("store.c1");
      chk("store.rvalid", s_lsu_rvalid, 32'd1);
      chk("store.err", s_lsu_err, 32'd1);
      mem_rvalid_i = 0; mem_err_i = 0;
      step("store.c2");

      // Reset while in WAIT_LSU, then the abandoned response arrives.
      lsu_req_i = 1; lsu_addr_i = 32'h80; mem_gnt_i = 1;
      step("rst.c0");
      lsu_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'hA5A5A5A5;
      rstn_i = 0;
      #1 chk_zero("rst.async");
      model_reset();
      step("rst.c1");
      rstn_i = 1; mem_rvalid_i = 1;
      step("rst.c2");
      chk("rst.dropped", s_lsu_rvalid, 32'd0);
      mem_rvalid_i = 0;
      step("rst.c3");
      chk("rst.proto_err", s_perr, 32'd1);

      // Randomized traffic from a clean reset.
      rstn_i = 0;
      step("rand.rst");
      rstn_i = 1;
      idle_inputs();
      for (int k = 0; k < 1500; k++) begin
         step("rand");
         if (!(ifu_req_i && !e_ifu_gnt)) begin
            ifu_req_i = ($urandom_range(0, 2) != 0);
            ifu_addr_i = $urandom() & 32'hFFFF_FFFC;
         end
         if (!(lsu_req_i && !e_lsu_gnt)) begin
            lsu_req_i = ($urandom_range(0, 2) != 0);
            lsu_we_i = 1'($urandom_range(0, 1));
            lsu_be_i = 4'($urandom_range(0, 15));
            lsu_addr_i = $urandom();
            lsu_wdata_i = $urandom();
         end
         mem_gnt_i = 1'($urandom_range(0, 1));
         mem_rvalid_i = (m_owner != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
         mem_err_i = 1'($urandom_range(0, 1));
         mem_rdata_i = $urandom();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
